secuenciador_filtro: RTL and testbench

- Sequences the shared multiply-accumulate datapath of the recursive (biquad) filter once per input sample.
- Steps a tap index through the feed-forward coefficients b0..b2 and then the feedback coefficients a1..a2. The index drives the coefficient multiplexers; a latched band select drives their sel inputs.
- Also issues accumulator clear, accumulate-enable, subtract, delay-line shift and a sample-done strobe.
- Sits between the sample-rate strobe generator and the MAC/coefficient-mux datapath.

---
 rtl/secuenciador_filtro.sv | 83 ++++++++
 tb/tb_secuenciador_filtro.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/secuenciador_filtro.sv
// secuenciador_filtro: sequences the shared biquad MAC datapath once per sample.
// Define SECUENCIADOR_OVERRUN_EN to add the sticky overrun output.
module secuenciador_filtro #(
  parameter int NUM_TAPS = 5,
  parameter int NUM_B = 3,
  parameter int MAC_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inicio,
  input  logic [1:0] sel_banda_in,
  output logic [1:0] sel_banda,
  output logic [2:0] coef_idx,
  output logic       mac_clr,
  output logic       mac_en,
  output logic       mac_resta,
  output logic       shift_en,
  output logic       ocupado,
  output logic       listo
`ifdef SECUENCIADOR_OVERRUN_EN
  ,
  output logic       overrun
`endif
);
  typedef enum logic [2:0] {IDLE, CLEAR, MAC, WAIT, UPDATE, DONE} state_t;
  state_t st, nxt;
  logic [2:0] nidx, wcnt, nw;
  logic [1:0] nsel;
  always_comb begin
    nxt = st;
    nidx = coef_idx;
    nw = wcnt;
    nsel = sel_banda;
    case (st)
      IDLE: if (inicio) begin
        nxt = CLEAR;
        nsel = sel_banda_in;
        nidx = '0;
      end
      CLEAR: nxt = MAC;
      MAC: if (coef_idx == 3'(NUM_TAPS - 1)) begin
        nxt = (MAC_LAT > 0) ? WAIT : UPDATE;
        nw = '0;
      end else nidx = coef_idx + 3'd1;
      WAIT: if (wcnt == 3'(MAC_LAT - 1)) nxt = UPDATE;
            else nw = wcnt + 3'd1;
      UPDATE: nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so they register alongside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= IDLE;
      coef_idx <= '0;
      wcnt <= '0;
      sel_banda <= '0;
      mac_clr <= 1'b0;
      mac_en <= 1'b0;
      mac_resta <= 1'b0;
      shift_en <= 1'b0;
      ocupado <= 1'b0;
      listo <= 1'b0;
    end else begin
      st <= nxt;
      coef_idx <= nidx;
      wcnt <= nw;
      sel_banda <= nsel;
      mac_clr <= nxt == CLEAR;
      mac_en <= nxt == MAC;
      mac_resta <= nxt == MAC && {1'b0, nidx} >= 4'(NUM_B);
      shift_en <= nxt == UPDATE;
      ocupado <= nxt != IDLE;
      listo <= nxt == DONE;
    end
  end
`ifdef SECUENCIADOR_OVERRUN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) overrun <= 1'b0;
    else if (inicio) overrun <= (st != IDLE) ? 1'b1 : (sel_banda_in == 2'b00) ? 1'b0 : overrun;
  end
`endif
endmodule

// File: tb/tb_secuenciador_filtro.sv
// tb_secuenciador_filtro: checks two sequencer configurations against a cycle-offset model.
module tb_secuenciador_filtro;
  logic clk = 1'b0, reset = 1'b0, inicio = 1'b0;
  logic [1:0] sel_in = 2'b00;
  logic [1:0] sb0, sb1;
  logic [2:0] ix0, ix1;
  logic c0, e0, r0, s0, o0, l0, c1, e1, r1, s1, o1, l1;
  int total = 0, bad = 0;
  int ph[2];
  logic [1:0] esel[2];
  bit idxk[2];
  bit ov;
`ifdef SECUENCIADOR_OVERRUN_EN
  logic ov0, ov1;
`endif

  always #5 clk = ~clk;

  secuenciador_filtro u0 (
    .clk(clk), .reset(reset), .inicio(inicio), .sel_banda_in(sel_in),
    .sel_banda(sb0), .coef_idx(ix0), .mac_clr(c0), .mac_en(e0), .mac_resta(r0),
    .shift_en(s0), .ocupado(o0), .listo(l0)
`ifdef SECUENCIADOR_OVERRUN_EN
    , .overrun(ov0)
`endif
  );

  secuenciador_filtro #(.NUM_TAPS(3), .NUM_B(3), .MAC_LAT(0)) u1 (
    .clk(clk), .reset(reset), .inicio(inicio), .sel_banda_in(sel_in),
    .sel_banda(sb1), .coef_idx(ix1), .mac_clr(c1), .mac_en(e1), .mac_resta(r1),
    .shift_en(s1), .ocupado(o1), .listo(l1)
`ifdef SECUENCIADOR_OVERRUN_EN
    , .overrun(ov1)
`endif
  );

  function automatic int nt_of(input int w); return w ? 3 : 5; endfunction
  function automatic int ml_of(input int w); return w ? 0 : 1; endfunction

  task automatic chk(input int w, input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL u%0d %s got=%0h exp=%0h t=%0t", w, tag, got, exp, $time);
    end
  endtask

  // k = clocks since the accepting edge; every output is a pure function of k.
  task automatic check_one(input int w, input logic [10:0] v);
    int k, nt, ml;
    k = ph[w];
    nt = nt_of(w);
    ml = ml_of(w);
    chk(w, "sel_banda", 8'(v[10:9]), 8'(esel[w]));
    chk(w, "mac_clr", 8'(v[5]), 8'(k == 1));
    chk(w, "mac_en", 8'(v[4]), 8'(k >= 2 && k <= nt + 1));
    chk(w, "mac_resta", 8'(v[3]), 8'(k >= 2 && k <= nt + 1 && k - 2 >= 3));
    chk(w, "shift_en", 8'(v[2]), 8'(k == nt + ml + 2));
    chk(w, "ocupado", 8'(v[1]), 8'(k >= 1));
    chk(w, "listo", 8'(v[0]), 8'(k == nt + ml + 3));
    if (k == 1) chk(w, "coef_idx", 8'(v[8:6]), 8'd0);
    else if (k >= 2 && k <= nt + 1) chk(w, "coef_idx", 8'(v[8:6]), 8'(k - 2));
    else if (k > nt + 1 && k <= nt + ml + 1) chk(w, "coef_idx", 8'(v[8:6]), 8'(nt - 1));
    else if (k == 0 && idxk[w]) chk(w, "coef_idx", 8'(v[8:6]), 8'd0);
  endtask

  task automatic check_all();
    check_one(0, {sb0, ix0, c0, e0, r0, s0, o0, l0});
    check_one(1, {sb1, ix1, c1, e1, r1, s1, o1, l1});
`ifdef SECUENCIADOR_OVERRUN_EN
    chk(0, "overrun", 8'(ov0), 8'(ov));
    chk(1, "overrun", 8'(ov1), 8'(ov));
`endif
  endtask

  task automatic advance();
    if (inicio) ov = (ph[0] != 0) ? 1'b1 : (sel_in == 2'b00) ? 1'b0 : ov;
    for (int w = 0; w < 2; w++) begin
      if (ph[w] == 0) begin
        if (inicio) begin
          ph[w] = 1;
          esel[w] = sel_in;
          idxk[w] = 1'b0;
        end
      end else ph[w] = (ph[w] == nt_of(w) + ml_of(w) + 3) ? 0 : ph[w] + 1;
    end
  endtask

  task automatic step(input bit ini, input logic [1:0] s);
    inicio = ini;
    sel_in = s;
    @(posedge clk);
    advance();
    #1;
    check_all();
    inicio = 1'b0;
  endtask

  task automatic areset();
    #2;
    reset = 1'b1;
    #1;
    for (int w = 0; w < 2; w++) begin
      ph[w] = 0;
      esel[w] = 2'b00;
      idxk[w] = 1'b1;
    end
    ov = 1'b0;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
  endtask

  initial begin
    logic [1:0] sels[4];
    sels = '{2'b01, 2'b10, 2'b11, 2'b00};
    areset();
    step(1'b1, 2'b10);
    repeat (10) step(1'b0, 2'b10);
    foreach (sels[i]) begin
      step(1'b1, sels[i]);
      repeat (9) step(1'b0, ~sels[i]);
    end
    repeat (3) step(1'b0, 2'b00);
    step(1'b1, 2'b01);
    repeat (3) step(1'b0, 2'b11);
    step(1'b1, 2'b11);
    repeat (5) step(1'b0, 2'b00);
    step(1'b1, 2'b10);
    repeat (12) step(1'b0, 2'b00);
    step(1'b1, 2'b00);
    repeat (10) step(1'b0, 2'b00);
    step(1'b1, 2'b11);
    repeat (4) step(1'b0, 2'b01);
    areset();
    repeat (12) step(1'b0, 2'b10);
    step(1'b1, 2'b01);
    repeat (11) step(1'b0, 2'b10);
    repeat (400) begin
      if ($urandom_range(99) == 0) areset();
      else step($urandom_range(3) == 0, 2'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
